adc081c021_i2c_target: RTL

- I2C target (slave) that answers the 2-byte conversion-result read of an ADC081C021.
- Lets the FPGA stand in for the ADC, either as a bench model for the I2C read master or as an on-board emulator.
- Samples SCL/SDA with the system clock and drives SDA open-drain.
- Returns a host-supplied 8-bit sample formatted as the ADC result word.

---
 rtl/adc081c021_i2c_target_if.sv | 11 +
 rtl/adc081c021_i2c_target.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc081c021_i2c_target_if.sv
// Host-side sample handshake of the ADC081C021 I2C target emulator.
// The target drives the status strobes; the host supplies the raw sample.
interface adc081c021_i2c_target_if;
    logic [7:0] sample_value;
    logic       sample_latch;
    logic       read_done;
    logic       busy;

    modport slave  (input sample_value, output sample_latch, read_done, busy);
    modport master (output sample_value, input sample_latch, read_done, busy);
endinterface

// File: rtl/adc081c021_i2c_target.sv
// ADC081C021 conversion-result read emulator: an I2C target that returns
// {4'b0, V, 4'b0} for a host sample V, repeating the word while the master ACKs.
// SCL/SDA are oversampled by sclk, synchronised, glitch filtered; SDA is open-drain.
// Optional: define ADC081C021_TGT_DEBUG_EN to add DEBUG_scl/DEBUG_sda/DEBUG_state.
module adc081c021_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h54,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic sclk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    adc081c021_i2c_target_if.slave host
`ifdef ADC081C021_TGT_DEBUG_EN
    ,
    output logic       DEBUG_scl,
    output logic       DEBUG_sda,
    output logic [2:0] DEBUG_state
`endif
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, TX, GET_ACK, WAIT_STOP} state_t;

    // index 1 = SCL, index 0 = SDA
    logic [1:0]                  raw, filt, filt_q;
    logic [1:0][SYNC_STAGES-1:0] sync;
    logic [1:0][CW-1:0]          fcnt;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t      state, state_d;
    logic        sda_oe, sda_oe_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  shreg, shreg_d;
    logic [15:0] tx_word, tx_d, fresh, word_sel;
    logic [7:0]  byte_cnt, byte_cnt_d;
    logic        half, half_d;
    logic        busy, busy_d, latch, latch_d, done, done_d;

    assign raw   = {scl, sda};
    assign fresh = {4'b0000, host.sample_value, 4'b0000};
    assign sda   = sda_oe ? 1'b0 : 1'bz;

    assign host.sample_latch = latch;
    assign host.read_done    = done;
    assign host.busy         = busy;

    // Synchroniser plus glitch filter: a level changes only after FILTER_LEN equal samples
    always_ff @(posedge sclk) begin
        if (rst) begin
            sync   <= '1;
            filt   <= '1;
            filt_q <= '1;
            fcnt   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
                if (sync[i][SYNC_STAGES-1] != filt[i]) begin
                    if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
                        filt[i] <= sync[i][SYNC_STAGES-1];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + CW'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
            filt_q <= filt;
        end
    end

    assign scl_rise  =  filt[1] & ~filt_q[1];
    assign scl_fall  = ~filt[1] &  filt_q[1];
    assign start_det =  filt_q[0] & ~filt[0] & filt[1] & filt_q[1];
    assign stop_det  = ~filt_q[0] &  filt[0] & filt[1] & filt_q[1];

    // Protocol state and datapath registers; sda_oe reset releases the bus on the same edge
    always_ff @(posedge sclk) begin
        if (rst) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_word  <= '0;
            byte_cnt <= '0;
            half     <= 1'b0;
            busy     <= 1'b0;
            latch    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            sda_oe   <= sda_oe_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            tx_word  <= tx_d;
            byte_cnt <= byte_cnt_d;
            half     <= half_d;
            busy     <= busy_d;
            latch    <= latch_d;
            done     <= done_d;
        end
    end

    // Next state: STOP beats START beats bit events; SDA only moves on scl_fall
    always_comb begin
        state_d    = state;
        sda_oe_d   = sda_oe;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        tx_d       = tx_word;
        byte_cnt_d = byte_cnt;
        half_d     = half;
        busy_d     = busy;
        latch_d    = 1'b0;
        done_d     = 1'b0;
        word_sel   = tx_word;
        if (stop_det) begin
            sda_oe_d   = 1'b0;
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = (byte_cnt != 8'd0);
            byte_cnt_d = '0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ADDR;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_d   = {shreg[6:0], filt[0]};
                        bit_cnt_d = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            if (shreg[0]) begin
                                sda_oe_d = 1'b1;
                                tx_d     = fresh;
                                latch_d  = 1'b1;
                                busy_d   = 1'b1;
                                half_d   = 1'b0;
                                state_d  = ACK_ADDR;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        sda_oe_d  = ~tx_word[15];
                        tx_d      = {tx_word[14:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        state_d   = TX;
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_d   = 1'b0;
                            byte_cnt_d = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
                            state_d    = GET_ACK;
                        end else begin
                            sda_oe_d  = ~tx_word[15];
                            tx_d      = {tx_word[14:0], 1'b0};
                            bit_cnt_d = bit_cnt + 4'd1;
                        end
                    end
                end
                GET_ACK: begin
                    if (scl_rise && filt[0]) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        // after the low byte the word is re-sampled, like a continuous ADC read
                        if (half) begin
                            word_sel = fresh;
                            latch_d  = 1'b1;
                            half_d   = 1'b0;
                        end else begin
                            half_d   = 1'b1;
                        end
                        sda_oe_d  = ~word_sel[15];
                        tx_d      = {word_sel[14:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        state_d   = TX;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADC081C021_TGT_DEBUG_EN
    assign DEBUG_scl   = filt[1];
    assign DEBUG_sda   = sda_oe ? 1'b0 : filt[0];
    assign DEBUG_state = state;
`endif
endmodule
